ldst_mem_responder: RTL and testbench

LDST_MEM_RESPONDER -- requirements
Module: ldst_mem_responder

---
 rtl/ldst_mem_responder_if.sv | 43 ++++
 rtl/ldst_mem_responder.sv | 129 ++++++++++++
 tb/tb_ldst_mem_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_mem_responder_if.sv
// Bundles the core-side load/store handshake and the memory-side bus.
//
// Handshake semantics, core side:
//   A request is accepted on a rising edge where iLDST_REQ=1 and oLDST_BUSY=0.
//   The responder then issues exactly one memory request.
// Handshake semantics, memory side:
//   A memory request is accepted on a rising edge where oMEM_REQ=1 and iMEM_BUSY=0.
//   One iMEM_VALID pulse later completes it, and one oLDST_VALID pulse follows.
interface ldst_mem_responder_if;
  logic        iLDST_REQ;
  logic        oLDST_BUSY;
  logic [1:0]  iLDST_ORDER;
  logic [3:0]  iLDST_MASK;
  logic        iLDST_RW;
  logic [31:0] iLDST_ADDR;
  logic [31:0] iLDST_DATA;
  logic        oLDST_VALID;
  logic [31:0] oLDST_DATA;
  logic        oMEM_REQ;
  logic        iMEM_BUSY;
  logic [3:0]  oMEM_MASK;
  logic        oMEM_RW;
  logic [31:0] oMEM_ADDR;
  logic [31:0] oMEM_DATA;
  logic        iMEM_VALID;
  logic [31:0] iMEM_DATA;

  // Responder view
  modport slave (
    input  iLDST_REQ, iLDST_ORDER, iLDST_MASK, iLDST_RW, iLDST_ADDR, iLDST_DATA,
    input  iMEM_BUSY, iMEM_VALID, iMEM_DATA,
    output oLDST_BUSY, oLDST_VALID, oLDST_DATA,
    output oMEM_REQ, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA
  );

  // Environment view: core arbiter plus memory
  modport master (
    output iLDST_REQ, iLDST_ORDER, iLDST_MASK, iLDST_RW, iLDST_ADDR, iLDST_DATA,
    output iMEM_BUSY, iMEM_VALID, iMEM_DATA,
    input  oLDST_BUSY, oLDST_VALID, oLDST_DATA,
    input  oMEM_REQ, oMEM_MASK, oMEM_RW, oMEM_ADDR, oMEM_DATA
  );
endinterface

// File: rtl/ldst_mem_responder.sv
// Load/store to memory responder.
// It takes one core request at a time and issues one big-endian, lane-masked
// memory request for it. Read data is then extracted back to a right-justified value.
// dbg_state exposes the FSM state: 0 IDLE, 1 ISSUE, 2 WAIT.
module ldst_mem_responder (
  input  logic                     iCLOCK,
  input  logic                     inRESET,
  ldst_mem_responder_if.slave      bus,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Attributes of the in-flight transaction that are needed at completion
  logic [1:0]  lat_order;
  logic [1:0]  lat_a;
  logic        accept;
  logic        complete;
  logic [31:0] place_data;
  logic [3:0]  place_mask;
  logic [31:0] read_data;
  logic [31:0] rd_shift;

  assign accept    = (state == IDLE) && bus.iLDST_REQ;
  assign complete  = (state == WAIT) && bus.iMEM_VALID;
  assign dbg_state = state;

  // State register
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.iLDST_REQ)  state_nxt = ISSUE;
      ISSUE:   if (!bus.iMEM_BUSY) state_nxt = WAIT;
      WAIT:    if (bus.iMEM_VALID) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    bus.oLDST_BUSY = (state != IDLE);
    bus.oMEM_REQ   = (state == ISSUE);
  end

  // Byte enables and lane placement of write data for the incoming request.
  // Half and word ignore the low address bits, which force-aligns them.
  always_comb begin
    place_mask = 4'b0000;
    place_data = 32'h0;
    case (bus.iLDST_ORDER)
      2'b00: begin
        place_mask = 4'b1000 >> bus.iLDST_ADDR[1:0];
        // Byte lane a sits at bit 8*(3-a); ~a == 3-a for a 2-bit value
        place_data = {24'h0, bus.iLDST_DATA[7:0]} << {~bus.iLDST_ADDR[1:0], 3'b000};
      end
      2'b01: begin
        place_mask = bus.iLDST_ADDR[1] ? 4'b0011 : 4'b1100;
        place_data = bus.iLDST_ADDR[1] ? {16'h0, bus.iLDST_DATA[15:0]}
                                       : {bus.iLDST_DATA[15:0], 16'h0};
      end
      2'b10: begin
        place_mask = 4'b1111;
        place_data = bus.iLDST_DATA;
      end
      default: begin
        // Raw write data is already lane-placed; only the disabled lanes are cleared
        place_mask = bus.iLDST_MASK;
        place_data = bus.iLDST_DATA & {{8{bus.iLDST_MASK[3]}}, {8{bus.iLDST_MASK[2]}},
                                       {8{bus.iLDST_MASK[1]}}, {8{bus.iLDST_MASK[0]}}};
      end
    endcase
  end

  // Read data extraction from the lanes selected by the latched request
  always_comb begin
    read_data = 32'h0;
    rd_shift  = bus.iMEM_DATA >> {~lat_a, 3'b000};
    case (lat_order)
      2'b00:   read_data = {24'h0, rd_shift[7:0]};
      2'b01:   read_data = lat_a[1] ? {16'h0, bus.iMEM_DATA[15:0]}
                                    : {16'h0, bus.iMEM_DATA[31:16]};
      default: read_data = bus.iMEM_DATA;
    endcase
  end

  // Latch the memory request fields at accept. They are held stable through ISSUE.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      bus.oMEM_MASK <= 4'b0000;
      bus.oMEM_RW   <= 1'b0;
      bus.oMEM_ADDR <= 32'h0;
      bus.oMEM_DATA <= 32'h0;
      lat_order     <= 2'b00;
      lat_a         <= 2'b00;
    end else if (accept) begin
      bus.oMEM_MASK <= place_mask;
      bus.oMEM_RW   <= bus.iLDST_RW;
      bus.oMEM_ADDR <= {bus.iLDST_ADDR[31:2], 2'b00};
      bus.oMEM_DATA <= place_data;
      lat_order     <= bus.iLDST_ORDER;
      lat_a         <= bus.iLDST_ADDR[1:0];
    end
  end

  // Completion pulse; read data is updated only by read completions
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      bus.oLDST_VALID <= 1'b0;
      bus.oLDST_DATA  <= 32'h0;
    end else begin
      bus.oLDST_VALID <= complete;
      if (complete && !bus.oMEM_RW) bus.oLDST_DATA <= read_data;
    end
  end

endmodule

// File: tb/tb_ldst_mem_responder.sv
// Directed bench for ldst_mem_responder.
// A table of single transactions is followed by hand sequences for stall,
// back-to-back, stray iMEM_VALID and reset in WAIT.
module tb_ldst_mem_responder;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

  ldst_mem_responder_if bus();

  ldst_mem_responder dut (
    .iCLOCK    (clk),
    .inRESET   (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_addr;
    logic [31:0] exp_mdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic [1:0] order, input logic [3:0] mask, input logic rw,
                           input logic [31:0] addr, input logic [31:0] data);
    bus.iLDST_REQ   = 1'b1;
    bus.iLDST_ORDER = order;
    bus.iLDST_MASK  = mask;
    bus.iLDST_RW    = rw;
    bus.iLDST_ADDR  = addr;
    bus.iLDST_DATA  = data;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_mem_req"}, 32'(bus.oMEM_REQ), 32'd0);
    check({tag, "_busy"}, 32'(bus.oLDST_BUSY), 32'd0);
    check({tag, "_valid"}, 32'(bus.oLDST_VALID), 32'd0);
    check({tag, "_mask"}, 32'(bus.oMEM_MASK), 32'd0);
    check({tag, "_rw"}, 32'(bus.oMEM_RW), 32'd0);
    check({tag, "_maddr"}, bus.oMEM_ADDR, 32'd0);
    check({tag, "_mdata"}, bus.oMEM_DATA, 32'd0);
    check({tag, "_ldata"}, bus.oLDST_DATA, 32'd0);
  endtask

  // One table transaction at minimum latency; starts and ends at a negedge in IDLE
  task automatic run_vec(input int i);
    @(negedge clk);
    drive_req(vecs[i].order, vecs[i].mask, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
    @(negedge clk);
    bus.iLDST_REQ = 1'b0;
    check($sformatf("v%0d_mem_req", i), 32'(bus.oMEM_REQ), 32'd1);
    check($sformatf("v%0d_busy", i), 32'(bus.oLDST_BUSY), 32'd1);
    check($sformatf("v%0d_mask", i), 32'(bus.oMEM_MASK), 32'(vecs[i].exp_mask));
    check($sformatf("v%0d_maddr", i), bus.oMEM_ADDR, vecs[i].exp_addr);
    check($sformatf("v%0d_mdata", i), bus.oMEM_DATA, vecs[i].exp_mdata);
    check($sformatf("v%0d_rw", i), 32'(bus.oMEM_RW), 32'(vecs[i].rw));
    @(negedge clk);
    check($sformatf("v%0d_wait_state", i), 32'(dbg_state), 32'd2);
    check($sformatf("v%0d_wait_mem_req", i), 32'(bus.oMEM_REQ), 32'd0);
    bus.iMEM_VALID = 1'b1;
    bus.iMEM_DATA  = vecs[i].mem_rdata;
    @(negedge clk);
    bus.iMEM_VALID = 1'b0;
    check($sformatf("v%0d_valid", i), 32'(bus.oLDST_VALID), 32'd1);
    check($sformatf("v%0d_ldata", i), bus.oLDST_DATA, vecs[i].exp_rdata);
    check($sformatf("v%0d_busy_done", i), 32'(bus.oLDST_BUSY), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_valid_off", i), 32'(bus.oLDST_VALID), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.iLDST_REQ   = 1'b0;
    bus.iLDST_ORDER = 2'b00;
    bus.iLDST_MASK  = 4'h0;
    bus.iLDST_RW    = 1'b0;
    bus.iLDST_ADDR  = 32'h0;
    bus.iLDST_DATA  = 32'h0;
    bus.iMEM_BUSY   = 1'b0;
    bus.iMEM_VALID  = 1'b0;
    bus.iMEM_DATA   = 32'h0;

    // Table. Write acks return junk data, so the held read value must stay
    vecs[0]  = '{2'b00, 4'h0,    1'b0, 32'h1001, 32'h0,        32'hAABBCCDD, 4'b0100, 32'h1000, 32'h0,        32'h000000BB};
    vecs[1]  = '{2'b01, 4'h0,    1'b1, 32'h2002, 32'h00001234, 32'h55555555, 4'b0011, 32'h2000, 32'h00001234, 32'h000000BB};
    vecs[2]  = '{2'b00, 4'h0,    1'b1, 32'h2000, 32'h000000EE, 32'h55555555, 4'b1000, 32'h2000, 32'hEE000000, 32'h000000BB};
    vecs[3]  = '{2'b10, 4'h0,    1'b0, 32'h3003, 32'h0,        32'h12345678, 4'b1111, 32'h3000, 32'h0,        32'h12345678};
    vecs[4]  = '{2'b01, 4'h0,    1'b0, 32'h4001, 32'h0,        32'hCAFEBABE, 4'b1100, 32'h4000, 32'h0,        32'h0000CAFE};
    vecs[5]  = '{2'b00, 4'h0,    1'b0, 32'h5003, 32'h0,        32'h11223344, 4'b0001, 32'h5000, 32'h0,        32'h00000044};
    vecs[6]  = '{2'b11, 4'b0110, 1'b1, 32'h6001, 32'hA1B2C3D4, 32'h55555555, 4'b0110, 32'h6000, 32'h00B2C300, 32'h00000044};
    vecs[7]  = '{2'b11, 4'b1010, 1'b0, 32'h7000, 32'h0,        32'hDEADBEEF, 4'b1010, 32'h7000, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{2'b00, 4'h0,    1'b1, 32'h8002, 32'hFFFFFF5A, 32'h55555555, 4'b0010, 32'h8000, 32'h00005A00, 32'hDEADBEEF};
    vecs[9]  = '{2'b01, 4'h0,    1'b1, 32'h9003, 32'hABCD5678, 32'h55555555, 4'b0011, 32'h9000, 32'h00005678, 32'hDEADBEEF};
    vecs[10] = '{2'b10, 4'h0,    1'b1, 32'hA001, 32'h01020304, 32'h55555555, 4'b1111, 32'hA000, 32'h01020304, 32'hDEADBEEF};

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    for (int i = 0; i < 11; i++) run_vec(i);

    // Memory stall for 3 cycles, with a stray iMEM_VALID during ISSUE
    @(negedge clk);
    drive_req(2'b10, 4'h0, 1'b0, 32'hB002, 32'h0);
    bus.iMEM_BUSY = 1'b1;
    @(negedge clk);
    bus.iLDST_REQ = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d_state", k), 32'(dbg_state), 32'd1);
      check($sformatf("stall%0d_mem_req", k), 32'(bus.oMEM_REQ), 32'd1);
      check($sformatf("stall%0d_busy", k), 32'(bus.oLDST_BUSY), 32'd1);
      check($sformatf("stall%0d_mask", k), 32'(bus.oMEM_MASK), 32'hF);
      check($sformatf("stall%0d_maddr", k), bus.oMEM_ADDR, 32'hB000);
      check($sformatf("stall%0d_valid", k), 32'(bus.oLDST_VALID), 32'd0);
      bus.iMEM_VALID = (k == 1);
      bus.iMEM_DATA  = 32'hFFFFFFFF;
      if (k == 2) bus.iMEM_BUSY = 1'b0;
      @(negedge clk);
    end
    bus.iMEM_VALID = 1'b0;
    check("stall_wait_state", 32'(dbg_state), 32'd2);
    check("stall_wait_mem_req", 32'(bus.oMEM_REQ), 32'd0);
    bus.iMEM_VALID = 1'b1;
    bus.iMEM_DATA  = 32'h01020304;
    @(negedge clk);
    bus.iMEM_VALID = 1'b0;
    check("stall_valid", 32'(bus.oLDST_VALID), 32'd1);
    check("stall_ldata", bus.oLDST_DATA, 32'h01020304);

    // Back-to-back: second request held high through the completion cycle
    @(negedge clk);
    drive_req(2'b00, 4'h0, 1'b0, 32'hC000, 32'h0);
    @(negedge clk);
    bus.iLDST_REQ = 1'b0;
    @(negedge clk);
    check("b2b_a_wait", 32'(dbg_state), 32'd2);
    bus.iMEM_VALID = 1'b1;
    bus.iMEM_DATA  = 32'h9A000000;
    drive_req(2'b01, 4'h0, 1'b1, 32'hD000, 32'h0000BEEF);
    @(negedge clk);
    bus.iMEM_VALID = 1'b0;
    check("b2b_a_valid", 32'(bus.oLDST_VALID), 32'd1);
    check("b2b_a_ldata", bus.oLDST_DATA, 32'h0000009A);
    check("b2b_a_busy", 32'(bus.oLDST_BUSY), 32'd0);
    @(negedge clk);
    bus.iLDST_REQ = 1'b0;
    check("b2b_b_mem_req", 32'(bus.oMEM_REQ), 32'd1);
    check("b2b_b_maddr", bus.oMEM_ADDR, 32'hD000);
    check("b2b_b_mask", 32'(bus.oMEM_MASK), 32'hC);
    check("b2b_b_mdata", bus.oMEM_DATA, 32'hBEEF0000);
    check("b2b_b_rw", 32'(bus.oMEM_RW), 32'd1);
    check("b2b_b_valid_off", 32'(bus.oLDST_VALID), 32'd0);
    @(negedge clk);
    bus.iMEM_VALID = 1'b1;
    bus.iMEM_DATA  = 32'h55555555;
    @(negedge clk);
    bus.iMEM_VALID = 1'b0;
    check("b2b_b_valid", 32'(bus.oLDST_VALID), 32'd1);
    check("b2b_b_ldata_held", bus.oLDST_DATA, 32'h0000009A);

    // Stray iMEM_VALID in IDLE
    @(negedge clk);
    bus.iMEM_VALID = 1'b1;
    bus.iMEM_DATA  = 32'h77777777;
    @(negedge clk);
    bus.iMEM_VALID = 1'b0;
    check("idle_stray_valid", 32'(bus.oLDST_VALID), 32'd0);
    check("idle_stray_state", 32'(dbg_state), 32'd0);
    check("idle_stray_ldata", bus.oLDST_DATA, 32'h0000009A);

    // Reset in WAIT, then a late completion after release
    @(negedge clk);
    drive_req(2'b00, 4'h0, 1'b1, 32'hE001, 32'h000000AB);
    @(negedge clk);
    bus.iLDST_REQ = 1'b0;
    @(negedge clk);
    check("rst_mid_wait", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.iMEM_VALID = 1'b1;
    bus.iMEM_DATA  = 32'hFFFFFFFF;
    @(negedge clk);
    bus.iMEM_VALID = 1'b0;
    check_idle_outputs("rst_late");
    @(negedge clk);
    check("rst_late_valid2", 32'(bus.oLDST_VALID), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
